word_loader: RTL and testbench
==============================

WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 Parameters (name, default, meaning): BW, 32, host beat width; DW, 198, RAM word width; AW, 6, RAM address width; NB, 7, beats per RAM word (ceil(DW/BW)).
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; all state on rising edge.
REQ-003 reset, in, 1, asynchronous, active-low reset.
REQ-004 cmd_valid, in, 1, host command present; cmd_ready, out, 1, loader accepts command.
REQ-005 cmd_write, in, 1, 1 = write RAM word, 0 = read RAM word; cmd_addr, in, AW, target RAM address.
REQ-006 in_valid, in, 1, write beat present; in_ready, out, 1, loader accepts beat; in_data, in, BW, write beat.
REQ-007 out_valid, out, 1, read beat present; out_ready, in, 1, host accepts beat; out_data, out, BW, read beat.
REQ-008 ram_sel, out, 1, host-access select to core RAM; ram_w, out, 1, RAM write strobe; ram_addr, out, AW; ram_data, out, DW; ram_out, in, DW, RAM read data, valid one cycle after ram_sel=1, ram_w=0.

Function
REQ-009 FSM states: IDLE, WFILL, WRITE, RADDR, RCAP, RSEND; reset state IDLE.
REQ-010 cmd_ready=1 only in IDLE; handshake on cmd_valid&cmd_ready latches cmd_addr; next state WFILL if cmd_write=1, else RADDR.
REQ-011 WFILL: in_ready=1; each in_valid&in_ready shifts in one beat, LS beat first; beat k fills bits [BW*k+BW-1 : BW*k]; beat NB-1 contributes only bits [DW-1-BW*(NB-1) : 0] of in_data (bits [5:0] at default), upper bits ignored.
REQ-012 Beat counter 0..NB-1; on acceptance of beat NB-1 counter returns to 0 and state moves to WRITE; in_valid while not in WFILL is ignored (in_ready=0).
REQ-013 WRITE lasts exactly one cycle: ram_sel=1, ram_w=1, ram_addr=latched addr, ram_data=assembled word; then IDLE.
REQ-014 Write latency: last beat accepted cycle t -> write strobe cycle t+1 -> cmd_ready=1 cycle t+2.
REQ-015 RADDR lasts one cycle: ram_sel=1, ram_w=0, ram_addr=latched addr; RCAP next cycle registers ram_out into read buffer, ram_sel=0; then RSEND.
REQ-016 RSEND: out_valid=1, out_data=buffer beat k LS first, beat NB-1 zero-extended above bit DW-1-BW*(NB-1); beat advances only on out_valid&out_ready; out_data stable while out_ready=0; after beat NB-1 accepted -> IDLE.
REQ-017 Read latency: command accepted cycle t -> first out_valid cycle t+3.
REQ-018 ram_sel=0 and ram_w=0 in every state except WRITE/RADDR; ram_w never 1 outside WRITE; ram_data holds last assembled word otherwise.
REQ-019 Addresses 0..2^AW-1 all legal; no wrap or address increment between commands.
REQ-020 Back-to-back commands: new command accepted no earlier than first cycle back in IDLE; no overlap of write and read.

Reset
REQ-021 reset=0 asynchronously forces IDLE, counter 0, assembly and read buffers 0, cmd_ready=0 while asserted, in_ready=0, out_valid=0, out_data=0, ram_sel=0, ram_w=0, ram_addr=0, ram_data=0.
REQ-022 reset mid-WFILL discards partial word, no ram_w pulse; reset mid-RSEND drops remaining beats; after release cmd_ready=1 from first clock edge.

Structure
REQ-023 Shared package tiny_pkg holds DW, AW, BW, NB constants and the state enum; no other typedefs.
REQ-024 One sub-module word_shifter (NB-beat shift register, load-parallel/shift-serial) SHALL be used for both assembly and readback.

Verification
REQ-025 Write 198'h115a25886512165251569195908560596a6695612620504191 to addr 0 via 7 beats -> single-cycle ram_sel=1, ram_w=1, ram_addr=0, ram_data=that word, cycle after beat 7.
REQ-026 Read addr 3 with RAM model returning 198'h1559546442405a181195655549614540592955a15a26984015 -> out beats 0x5a26984015 slices LS first, beat 6 = 0x00000015&0x3f zero-extended, first out_valid 3 cycles after command.
REQ-027 Write with in_valid gaps of 0-3 random cycles and beat 6 upper bits = 0xFFFFFFC0 -> ram_data bits 197:192 from beat 6 [5:0] only, upper garbage absent.
REQ-028 Read with out_ready held 0 for 5 cycles on beat 2 -> out_data and out_valid constant, no beat skipped.
REQ-029 reset=0 after beat 4 of a write to addr 63 -> no ram_w pulse ever; subsequent read of addr 63 returns prior RAM contents.
REQ-030 Write addr 63 then immediate read addr 63 -> read returns written word; cmd_ready low throughout both transactions.

Source files
------------

// File: rtl/tiny_pkg.sv
// Constants and state encoding shared by the word loader and its beat shifter.
package tiny_pkg;

  localparam int BW = 32;
  localparam int DW = 198;
  localparam int AW = 6;
  localparam int NB = 7;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WRITE,
    RADDR,
    RCAP,
    RSEND
  } state_t;

endpackage

// File: rtl/word_shifter.sv
// NB-beat shift register: parallel load of a whole word, serial shift of one
// beat per cycle towards beat 0 with a new beat entering at the top.
module word_shifter #(
  parameter int BW = tiny_pkg::BW,
  parameter int NB = tiny_pkg::NB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [NB*BW-1:0] load_data,
  input  logic [BW-1:0]    shift_in,
  output logic [NB*BW-1:0] word
);
  import tiny_pkg::*;

  logic [NB*BW-1:0] word_reg;
  logic [NB*BW-1:0] shifted;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_beat
      if (gi == NB - 1) begin : g_top
        assign shifted[gi*BW +: BW] = shift_in;
      end else begin : g_low
        assign shifted[gi*BW +: BW] = word_reg[(gi+1)*BW +: BW];
      end
    end
  endgenerate

  // Load wins over shift so a capture is never corrupted by a stray shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg <= '0;
    end else if (load) begin
      word_reg <= load_data;
    end else if (shift) begin
      word_reg <= shifted;
    end
  end

  assign word = word_reg;

endmodule

// File: rtl/word_loader.sv
// Host-side loader that moves DW-bit RAM words in and out as NB beats of BW
// bits, least-significant beat first.
module word_loader #(
  parameter int BW = tiny_pkg::BW,
  parameter int DW = tiny_pkg::DW,
  parameter int AW = tiny_pkg::AW,
  parameter int NB = tiny_pkg::NB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          ram_sel,
  output logic          ram_w,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_out
);
  import tiny_pkg::*;

  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = NB * BW;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] ram_data_reg;
  logic          ready_reg;

  logic          addr_load;
  logic          word_done;
  logic          asm_shift;
  logic          rd_load;
  logic          rd_shift;
  logic [PW-1:0] asm_word;
  logic [PW-1:0] asm_word_next;
  logic [PW-1:0] rd_word;
  logic [PW-1:0] rd_load_data;

  word_shifter #(.BW(BW), .NB(NB)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .shift     (asm_shift),
    .load_data ('0),
    .shift_in  (in_data),
    .word      (asm_word)
  );

  word_shifter #(.BW(BW), .NB(NB)) u_rd (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_load),
    .shift     (rd_shift),
    .load_data (rd_load_data),
    .shift_in  ('0),
    .word      (rd_word)
  );

  // The final beat's bits above DW-1 fall off here, so host garbage never lands.
  assign asm_word_next = {in_data, asm_word[PW-1:BW]};
  assign rd_load_data  = {{(PW-DW){1'b0}}, ram_out};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ram_sel    = 1'b0;
    ram_w      = 1'b0;
    addr_load  = 1'b0;
    word_done  = 1'b0;
    asm_shift  = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = ready_reg;
        if (cmd_valid && ready_reg) begin
          addr_load  = 1'b1;
          cnt_next   = '0;
          state_next = cmd_write ? WFILL : RADDR;
        end
      end
      WFILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          asm_shift = 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            word_done  = 1'b1;
            cnt_next   = '0;
            state_next = WRITE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WRITE: begin
        ram_sel    = 1'b1;
        ram_w      = 1'b1;
        state_next = IDLE;
      end
      RADDR: begin
        ram_sel    = 1'b1;
        state_next = RCAP;
      end
      RCAP: begin
        rd_load    = 1'b1;
        state_next = RSEND;
      end
      RSEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_shift = 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ready_reg keeps cmd_ready low during reset and until the first edge after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ready_reg    <= 1'b0;
      addr_reg     <= '0;
      ram_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= 1'b1;
      if (addr_load) begin
        addr_reg <= cmd_addr;
      end
      if (word_done) begin
        ram_data_reg <= asm_word_next[DW-1:0];
      end
    end
  end

  assign ram_addr = addr_reg;
  assign ram_data = ram_data_reg;
  assign out_data = out_valid ? rd_word[BW-1:0] : '0;

  logic unused_bits;
  assign unused_bits = ^{asm_word_next[PW-1:DW], asm_word[BW-1:0], rd_word[PW-1:BW]};

  a_write_only_in_write: assert property (@(posedge clk) disable iff (!reset)
    ram_w |-> (ram_sel && state_reg == WRITE));

  a_read_beat_held: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_word_loader.sv
// Randomised bench for word_loader against a word-level reference memory.
module tb_word_loader;
  import tiny_pkg::*;

  localparam int PW = NB * BW;
  localparam logic [DW-1:0] WR_WORD = 198'h115a25886512165251569195908560596a6695612620504191;
  localparam logic [DW-1:0] RD_WORD = 198'h1559546442405a181195655549614540592955a15a26984015;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          ram_sel;
  logic          ram_w;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out = '0;

  logic [DW-1:0] ram_mem [1<<AW] = '{default: '0};
  logic [DW-1:0] ref_mem [1<<AW] = '{default: '0};
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [DW-1:0] preload_data = '0;
  int            wr_pulses = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [PW-1:0] beats_v = '0;

  word_loader dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_sel   (ram_sel),
    .ram_w     (ram_w),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_out   (ram_out)
  );

  always #5 clk = ~clk;

  // Core RAM: registered read one cycle after select, write on strobe.
  always @(posedge clk) begin
    if (preload_en) ram_mem[preload_addr] <= preload_data;
    else if (ram_sel && ram_w) begin
      ram_mem[ram_addr] <= ram_data;
      wr_pulses <= wr_pulses + 1;
    end else if (ram_sel) ram_out <= ram_mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Spec-level model: beat k supplies bits BW*k upward, word truncated to DW bits.
  function automatic logic [DW-1:0] model_word(input logic [PW-1:0] bv);
    logic [PW-1:0] acc = '0;
    for (int k = 0; k < NB; k++) acc = acc | (PW'(bv[k*BW +: BW]) << (BW * k));
    return acc[DW-1:0];
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic [DW-1:0] w, input int k);
    logic [PW-1:0] ext = PW'(w);
    return BW'(ext >> (BW * k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, 256'(cmd_ready), 256'(1));
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_outs"}, 256'({cmd_ready, in_ready, out_valid, ram_sel, ram_w, ram_addr, out_data, ram_data}), 256'(0));
    tick();
    check({tag, "_held"}, 256'({cmd_ready, ram_w, out_valid}), 256'(0));
    in_valid = 1'b0;
    out_ready = 1'b0;
    cmd_valid = 1'b0;
    reset = 1'b1;
    check({tag, "_rel"}, 256'(cmd_ready), 256'(0));
    tick();
    check({tag, "_ready"}, 256'(cmd_ready), 256'(1));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input bit gaps);
    logic [DW-1:0] exp_w;
    int base;
    exp_w = model_word(beats_v);
    wait_cmd_ready("wr_cmd_ready");
    in_valid = 1'b1;
    in_data = $urandom;
    check("wr_in_ready_idle", 256'(in_ready), 256'(0));
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = a;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b0;
    check("wr_cmd_ready_low", 256'(cmd_ready), 256'(0));
    base = wr_pulses;
    for (int k = 0; k < NB; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      in_data = beats_v[k*BW +: BW];
      in_valid = 1'b1;
      check("wr_in_ready", 256'({in_ready, ram_w}), 256'(2));
      tick();
      in_valid = 1'b0;
      in_data = $urandom;
    end
    check("wr_strobe", 256'({ram_sel, ram_w, cmd_ready}), 256'(6));
    check("wr_addr", 256'(ram_addr), 256'(a));
    check("wr_data", 256'(ram_data), 256'(exp_w));
    tick();
    check("wr_after", 256'({ram_sel, ram_w, cmd_ready}), 256'(1));
    check("wr_data_hold", 256'(ram_data), 256'(exp_w));
    check("wr_pulses", 256'(wr_pulses - base), 256'(1));
    ref_mem[a] = exp_w;
    $display("write addr=%0d word=%0h", a, exp_w);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int stall_k, input int stall_n, input int abort_at);
    logic [BW-1:0] exp_b;
    wait_cmd_ready("rd_cmd_ready");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = a;
    out_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("rd_raddr", 256'({out_valid, ram_sel, ram_w, cmd_ready}), 256'(4));
    check("rd_raddr_addr", 256'(ram_addr), 256'(a));
    tick();
    check("rd_rcap", 256'({out_valid, ram_sel, ram_w, cmd_ready}), 256'(0));
    tick();
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        apply_reset("rd_abort");
        check("rd_abort_idle", 256'(out_valid), 256'(0));
        $display("read addr=%0d aborted at beat %0d", a, k);
        return;
      end
      exp_b = model_beat(ref_mem[a], k);
      check("rd_valid", 256'({out_valid, cmd_ready}), 256'(2));
      check("rd_beat", 256'(out_data), 256'(exp_b));
      if (k == stall_k) begin
        repeat (stall_n) begin
          tick();
          check("rd_stall", 256'({out_valid, out_data}), 256'({1'b1, exp_b}));
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("rd_done", 256'({out_valid, cmd_ready}), 256'(1));
    $display("read addr=%0d word=%0h", a, ref_mem[a]);
  endtask

  initial begin
    logic [AW-1:0] a;
    int base;
    repeat (2) @(posedge clk);
    #1;
    check("por_outs", 256'({cmd_ready, in_ready, out_valid, ram_sel, ram_w, ram_addr, out_data, ram_data}), 256'(0));
    reset = 1'b1;
    check("por_rel", 256'(cmd_ready), 256'(0));
    tick();
    check("por_ready", 256'(cmd_ready), 256'(1));

    beats_v = PW'(WR_WORD);
    do_write(6'd0, 1'b0);

    preload_en = 1'b1;
    preload_addr = 6'd3;
    preload_data = RD_WORD;
    tick();
    preload_en = 1'b0;
    ref_mem[3] = RD_WORD;
    do_read(6'd3, NB, 0, NB);

    for (int k = 0; k < NB; k++) beats_v[k*BW +: BW] = $urandom;
    beats_v[(NB-1)*BW +: BW] = 32'hFFFFFFC0 | 32'($urandom_range(0, 63));
    a = 6'($urandom_range(4, 62));
    do_write(a, 1'b1);
    do_read(a, 2, 5, NB);

    for (int k = 0; k < NB; k++) beats_v[k*BW +: BW] = $urandom;
    do_write(6'd63, 1'b0);
    do_read(6'd63, NB, 0, NB);

    wait_cmd_ready("part_cmd_ready");
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 6'd63;
    tick();
    cmd_valid = 1'b0;
    base = wr_pulses;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      in_valid = 1'b1;
      tick();
    end
    apply_reset("rst_mid_wr");
    repeat (4) tick();
    check("rst_no_pulse", 256'(wr_pulses - base), 256'(0));
    do_read(6'd63, NB, 0, NB);

    do_read(6'd3, NB, 0, 2);
    do_read(6'd3, 4, 2, NB);

    for (int i = 0; i < 12; i++) begin
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NB; k++) beats_v[k*BW +: BW] = $urandom;
        do_write(a, 1'b1);
      end else begin
        do_read(a, $urandom_range(0, NB - 1), $urandom_range(0, 3), NB);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
